// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared pipeline encodings used by the fetch stage
package instruction_fetch_pkg;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_e;

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-addressed instruction store, sync write, async read
module instruction_memory #(
  parameter int NBITS = 32,
  parameter int MEM_DEPTH = 256,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [NBITS-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [NBITS-1:0] o_rdata
);

  // No reset: program contents must survive a pipeline reset.
  logic [NBITS-1:0] mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, next-PC select, halt detection and cycle counter
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int MEM_DEPTH = 256,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_hazard_detected,
  input  logic [1:0]       i_pc_src,
  input  logic [NBITS-1:0] i_branch_addr,
  input  logic [NBITS-1:0] i_jump_addr,
  input  logic [NBITS-1:0] i_jr_addr,
  input  logic             i_load_we,
  input  logic [AW-1:0]    i_load_addr,
  input  logic [NBITS-1:0] i_load_data,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_instruction,
  output logic [NBITS-1:0] o_pc_current,
  output logic             o_halt,
  output logic [NBITS-1:0] o_cycle_count
);

  logic [NBITS-1:0] pc;
  logic [NBITS-1:0] pc_plus4;
  logic [NBITS-1:0] target;
  logic [NBITS-1:0] next_pc;
  logic [NBITS-1:0] cycle_count;
  logic             halted;
  logic             advance;
  logic             is_halt;

  instruction_memory #(
    .NBITS(NBITS),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_imem (
    .i_clk  (i_clk),
    .i_we   (i_load_we & ~i_enable),
    .i_waddr(i_load_addr),
    .i_wdata(i_load_data),
    .i_raddr(pc[AW+1:2]),
    .o_rdata(o_instruction)
  );

  assign pc_plus4 = pc + NBITS'(4);
  assign advance  = i_enable & ~i_hazard_detected & ~halted;
  assign is_halt  = (o_instruction == NBITS'(HALT_INSTR));

  always_comb begin
    target = pc_plus4;
    case (pc_src_e'(i_pc_src))
      PC_SRC_SEQ:    target = pc_plus4;
      PC_SRC_BRANCH: target = i_branch_addr;
      PC_SRC_JUMP:   target = i_jump_addr;
      PC_SRC_JR:     target = i_jr_addr;
      default:       target = pc_plus4;
    endcase
  end

  // Redirect targets are byte addresses; force word alignment.
  assign next_pc = target & ~NBITS'(3);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc          <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (i_enable && !halted) cycle_count <= cycle_count + NBITS'(1);
      if (advance) begin
        if (is_halt) halted <= 1'b1;
        else         pc     <= next_pc;
      end
    end
  end

  assign o_pc          = pc_plus4;
  assign o_pc_current  = pc;
  assign o_halt        = halted;
  assign o_cycle_count = cycle_count;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter NBITS, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, meaning instruction memory depth in words; AW = log2(MEM_DEPTH).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_enable  input  1  run/step enable from debug unit; low = frozen/program-load mode.
REQ-006 SHALL have port i_hazard_detected  input  1  stall request from hazard unit.
REQ-007 SHALL have port i_pc_src  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-008 SHALL have ports i_branch_addr, i_jump_addr, i_jr_addr  input  NBITS each  byte-address redirect targets.
REQ-009 SHALL have ports i_load_we (1), i_load_addr (AW, word index), i_load_data (NBITS)  input  program-load write port.
REQ-010 SHALL have port o_pc  output  NBITS  PC+4 of fetched instruction, to IF/ID register.
REQ-011 SHALL have port o_instruction  output  NBITS  instruction at current PC, to IF/ID register.
REQ-012 SHALL have ports o_pc_current (NBITS), o_halt (1), o_cycle_count (NBITS)  output  debug observability.

Function
REQ-013 SHALL read o_instruction combinationally from memory word PC[AW+1:2]; PC above memory range wraps modulo MEM_DEPTH.
REQ-014 SHALL drive o_pc = PC + 4 combinationally, wrapping modulo 2^NBITS.
REQ-015 SHALL update PC on a clock edge only when i_enable=1, i_hazard_detected=0 and halted=0 ("advance").
REQ-016 SHALL load on advance: 00 -> PC+4; 01 -> i_branch_addr; 10 -> i_jump_addr; 11 -> i_jr_addr; bits [1:0] forced to 0.
REQ-017 SHALL let stall win over redirect: with i_hazard_detected=1, PC holds regardless of i_pc_src.
REQ-018 SHALL implement no flush; the branch delay slot instruction is fetched normally.
REQ-019 SHALL set halted on the edge where advance conditions hold and o_instruction equals HALT_INSTR (32'hFFFF_FFFF); PC does not advance that edge.
REQ-020 SHALL keep halted set until reset; o_halt = halted; PC and o_instruction frozen on the HALT word.
REQ-021 SHALL increment o_cycle_count (wrapping) on every edge with i_enable=1 and halted=0, including stall cycles.
REQ-022 SHALL write i_load_data to word i_load_addr on an edge only when i_load_we=1 and i_enable=0; writes with i_enable=1 are ignored.
REQ-023 SHALL return newly written data on combinational read the cycle after the write edge (no read-during-write bypass required).
REQ-024 SHALL hold all state while i_enable=0 except memory writes; single-step = one-cycle i_enable pulse = exactly one advance.

Reset
REQ-025 SHALL on i_rst=1, asynchronously: PC=0, halted=0, o_cycle_count=0; hence o_pc=4, o_pc_current=0.
REQ-026 SHALL NOT clear instruction memory on reset; program contents survive reset.
REQ-027 SHALL, on reset asserted mid-stall or mid-redirect, discard the pending update; first post-reset fetch is from address 0.

Structure
REQ-028 SHALL take HALT_INSTR, NOP (32'h0) and PC_SRC_SEQ/BRANCH/JUMP/JR encodings from the shared pipeline package.
REQ-029 SHALL instantiate one sub-module, instruction_memory (parameters NBITS, MEM_DEPTH; one sync write port, one async read port).

Verification
REQ-030 Load words 0..3 with 0x1,0x2,0x3,0xFFFFFFFF, reset, enable -> o_instruction 0x1,0x2,0x3 on cycles 0-2, o_halt=1 after cycle 3, o_pc_current stuck at 0xC.
REQ-031 At PC=0x8 drive i_pc_src=01, i_branch_addr=0x43 -> next PC=0x40, o_pc=0x44.
REQ-032 Hold i_hazard_detected=1 for 3 cycles with i_pc_src=10, i_jump_addr=0x80 -> PC unchanged, o_cycle_count +3; on release PC=0x80.
REQ-033 i_enable=0 with i_load_we=1, i_load_addr=5, data 0xDEAD -> word 5 reads 0xDEAD; same write with i_enable=1 -> word unchanged.
REQ-034 Assert i_rst asynchronously between edges while PC=0x10 -> PC, o_cycle_count, o_halt go to 0 immediately; memory contents intact.
REQ-035 Pulse i_enable for one cycle five times -> PC advances exactly 0x14, o_cycle_count=5.
